midi_custom_rx: RTL and testbench
=================================

# midi_custom_rx

MIDI serial input receiver and message assembler: deserialises the 31 250 baud, 8-N-1, LSB-first MIDI line and packs complete channel-voice messages into a 24-bit word. Sits between the MIDI opto-isolator input pin and the synth voice/control logic. It runs from the 50 MHz system clock.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 31_250: MIDI bit rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (1600 at defaults).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset. Synchronous, active-high despite the legacy name.
- `serial` in 1: raw MIDI line. Idle is high. Asynchronous to `clk`.
- `out_bytes` out 24: last complete message as {status, data1, data2}.
- `out_valid` out 1: one-cycle pulse when `out_bytes` updates.
- `state` out 4: debug. Encoded as {byte_idx[1:0], rx_state[1:0]}.

## Operation
- **Input synchroniser:** `serial` passes through 2 flops, reset value 1. All decisions use the synchronised value `s`.
- **Receiver FSM (`rx_state`):**
  - IDLE (0): wait for `s` = 0, then clear the counter and go to START.
  - START (1): at count `CLKS_PER_BIT/2 - 1`, if `s` = 0 go to DATA; otherwise it is a glitch and the FSM returns to IDLE.
  - DATA (2): sample `s` every `CLKS_PER_BIT` cycles, which is mid-bit. Shift LSB-first into `rx_byte`. After 8 samples go to STOP.
  - STOP (3): sample once more one bit period later. If `s` = 1 the byte is accepted; if `s` = 0 it is a framing error and the byte is discarded. Either way return to IDLE.
  - A new start edge is accepted on the cycle after return to IDLE. Back-to-back frames with no idle gap must be received.
- **Message assembler (`byte_idx`):** acts on each accepted byte.
  - Byte 0xF8–0xFF (real-time): ignored. State and running status are unchanged.
  - Byte 0xF0–0xF7 (system common/SysEx): clears the running status, `byte_idx` goes to 0, and nothing is output.
  - Byte 0x80–0xEF (status): latch it as the status, clear data1 and data2, `byte_idx` goes to 1.
  - Data byte (bit 7 = 0) with `byte_idx` = 1: latch data1.
    - If the status is 0xC_ or 0xD_, output {status, data1, 8'h00}.
    - Otherwise `byte_idx` goes to 2.
  - Data byte with `byte_idx` = 2: output {status, data1, data2} and `byte_idx` goes to 0.
  - Data byte with `byte_idx` = 0: handled by running status; see Configuration.
  - On output, `out_bytes` is loaded and `out_valid` pulses in the same cycle.
- **Reset values:**
  - `out_bytes` = 24'h000000, `out_valid` = 0, `state` = 4'h0.
  - Running status is cleared, shift register and counters are 0, synchroniser flops are 1.
- Reset asserted mid-frame or mid-message aborts everything. The next falling edge after reset release starts a fresh frame.

## Timing
- Bit period is `CLKS_PER_BIT` cycles (32 µs at defaults). Sampling is at the mid-bit point.
- Relative to the `serial` falling edge, the stop bit is sampled about 9.5 bit periods plus 2 synchroniser cycles later.
- `out_bytes` and `out_valid` update on the cycle after the accepted stop-bit sample of the message's final byte, i.e. about 9.5 bit periods plus 3 cycles after that byte's start edge.
- `out_bytes` holds its value until the next complete message.
- Accepted baud tolerance: ±2 %. The counter restarts on each frame.

## Configuration
- `MIDI_RUNNING_STATUS_EN`
  - Defined: a data byte arriving with `byte_idx` = 0 and a valid latched status is treated as data1 of a new message with that status.
  - Not defined: such a data byte is discarded, and every message must carry its own status byte.
  - In both cases the latched status is cleared by reset and by 0xF0–0xF7.

## Test plan
- **Note-on:** after reset, send 0x90, 0x04, 0x7F back-to-back, each frame exactly 1600 clocks per bit.
  - Required: `out_bytes` = 24'h90047F, with one `out_valid` pulse about 9.5 bits after the third start edge.
  - Required: `out_bytes` = 0 beforehand.
- **Framing error:** send 0x90 with stop bit = 0, then 0x04 and 0x7F.
  - Required: no `out_valid`, and `out_bytes` stays 0.
- **Glitch:** a low pulse of 400 clocks on an idle line.
  - Required: returns to IDLE with no byte accepted.
  - Required: a following 0x90 0x3C 0x40 gives 24'h903C40.
- **Program change:** 0xC5 0x12.
  - Required: 24'hC51200 after the second byte.
- **Real-time interleave and running status:** 0x90 0x3C 0xF8 0x40 gives 24'h903C40.
  - Then 0x3E 0x00 follows.
  - With `MIDI_RUNNING_STATUS_EN` defined: 24'h903E00.
  - Without it: no new output.
- **Reset mid-message:** assert `rst_n` after 0x90 0x04.
  - Required: all outputs return to 0.
  - Required: a subsequent 0x7F alone produces no output.

Source files
------------

// File: rtl/midi_custom_rx.sv
// MIDI 8-N-1 serial receiver plus channel-voice message assembler.
// Define MIDI_RUNNING_STATUS_EN to enable running-status reception.
module midi_custom_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic        clk,
  input  logic        rst_n,      // active-high synchronous reset despite the name
  input  logic        serial,
  output logic [23:0] out_bytes,
  output logic        out_valid,
  output logic [3:0]  state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;

  rx_state_t      rx_state, rx_next;
  logic [1:0]     sync_q;
  logic           s;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     rx_byte;
  logic           byte_ok;
  logic           half_done, bit_done;
  logic [7:0]     status;
  logic [7:0]     data1;
  logic [1:0]     byte_idx;
  logic           two_byte;

  assign s         = sync_q[1];
  assign half_done = (cnt == CW'(HALF_BIT - 1));
  assign bit_done  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign two_byte  = (status[7:5] == 3'b110);  // 0xC_ program change, 0xD_ channel pressure
  assign state     = {byte_idx, rx_state};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q   <= 2'b11;
      rx_state <= IDLE;
    end else begin
      sync_q   <= {sync_q[0], serial};
      rx_state <= rx_next;
    end
  end

  // NOTE: next-state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      IDLE:  if (!s) rx_next = START;
      START: if (half_done) rx_next = s ? IDLE : DATA;
      DATA:  if (bit_done && bit_cnt == 3'd7) rx_next = STOP;
      STOP:  if (bit_done) rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      rx_byte <= '0;
      byte_ok <= 1'b0;
    end else begin
      byte_ok <= 1'b0;
      unique case (rx_state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
        end
        START: cnt <= half_done ? '0 : cnt + 1'b1;
        DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            rx_byte <= {s, rx_byte[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          cnt     <= bit_done ? '0 : cnt + 1'b1;
          byte_ok <= bit_done && s;  // low stop bit is a framing error: byte dropped
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      status    <= '0;
      data1     <= '0;
      byte_idx  <= '0;
      out_bytes <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (byte_ok) begin
        if (rx_byte[7:4] == 4'hF) begin
          // 0xF8-0xFF real-time bytes pass through without touching anything
          if (!rx_byte[3]) begin
            status   <= '0;
            byte_idx <= '0;
          end
        end else if (rx_byte[7]) begin
          status   <= rx_byte;
          data1    <= '0;
          byte_idx <= 2'd1;
        end else begin
          unique case (byte_idx)
            2'd1: begin
              data1 <= rx_byte;
              if (two_byte) begin
                out_bytes <= {status, rx_byte, 8'h00};
                out_valid <= 1'b1;
                byte_idx  <= 2'd0;
              end else begin
                byte_idx <= 2'd2;
              end
            end
            2'd2: begin
              out_bytes <= {status, data1, rx_byte};
              out_valid <= 1'b1;
              byte_idx  <= 2'd0;
            end
            default: begin
`ifdef MIDI_RUNNING_STATUS_EN
              if (status[7]) begin
                data1 <= rx_byte;
                if (two_byte) begin
                  out_bytes <= {status, rx_byte, 8'h00};
                  out_valid <= 1'b1;
                end else begin
                  byte_idx <= 2'd2;
                end
              end
`endif
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_custom_rx.sv
// Self-checking bench for midi_custom_rx: a byte-level message model predicts
// every out_valid pulse and the held out_bytes value, checked on every cycle.
module tb_midi_custom_rx;

  localparam int CLK_HZ  = 3_125_000;
  localparam int BAUD    = 31_250;
  localparam int CPB     = CLK_HZ / BAUD;            // 100 clocks per bit
  // start edge -> 2 sync flops + detect, half bit, 9 bit periods, one assembler cycle
  localparam int DUE_OFS = 4 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        serial = 1'b1;
  logic [23:0] out_bytes;
  logic        out_valid;
  logic [3:0]  state;

  midi_custom_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial    (serial),
    .out_bytes (out_bytes),
    .out_valid (out_valid),
    .state     (state)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pulses = 0;

  typedef struct {
    int          due;
    logic [23:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] hold = '0;

  // message model state: m_status < 0 means no latched status
  int m_status = -1;
  int m_idx    = 0;
  int m_d1     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void emit(input int due, input int s, input int d1, input int d2);
    exp_t e;
    e.due = due;
    e.val = 24'((s << 16) | (d1 << 8) | d2);
    exp_q.push_back(e);
  endfunction

  function automatic bit is_two_byte(input int s);
    return (s / 16 == 12) || (s / 16 == 13);
  endfunction

  function automatic void model_byte(input int b, input int due);
    if (b >= 248) return;
    if (b >= 240) begin
      m_status = -1;
      m_idx    = 0;
    end else if (b >= 128) begin
      m_status = b;
      m_d1     = 0;
      m_idx    = 1;
    end else if (m_idx == 1) begin
      m_d1 = b;
      if (is_two_byte(m_status)) begin
        emit(due, m_status, b, 0);
        m_idx = 0;
      end else begin
        m_idx = 2;
      end
    end else if (m_idx == 2) begin
      emit(due, m_status, m_d1, b);
      m_idx = 0;
    end else begin
`ifdef MIDI_RUNNING_STATUS_EN
      if (m_status >= 0) begin
        m_d1 = b;
        if (is_two_byte(m_status)) emit(due, m_status, b, 0);
        else m_idx = 2;
      end
`endif
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // every cycle out of reset: out_valid only on a predicted cycle, out_bytes equal to the model
  always @(negedge clk) begin
    logic exp_v;
    if (!rst_n) begin
      exp_v = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        hold  = exp_q[0].val;
        exp_v = 1'b1;
        void'(exp_q.pop_front());
      end
      if (out_valid) pulses++;
      check("cycle", {7'd0, out_valid, out_bytes}, {7'd0, exp_v, hold});
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop = 1'b1);
    if (good_stop) model_byte(int'(b), cyc + DUE_OFS);
    serial = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      wait_clks(CPB);
    end
    serial = good_stop;
    wait_clks(CPB);
    serial = 1'b1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b1;
    serial   = 1'b1;
    exp_q.delete();
    m_status = -1;
    m_idx    = 0;
    m_d1     = 0;
    hold     = '0;
    wait_clks(3);
    rst_n  = 1'b0;
    pulses = 0;
    check("rst_out_bytes", 32'(out_bytes), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_state", 32'(state), 32'h0);
  endtask

  initial begin
    wait_clks(2);

    // note-on, back-to-back frames
    do_reset();
    send_byte(8'h90);
    send_byte(8'h04);
    check("noteon_before", 32'(out_bytes), 32'h0);
    send_byte(8'h7F);
    wait_clks(2 * CPB);
    check("noteon_bytes", 32'(out_bytes), 32'h90047F);
    check("noteon_model", 32'(hold), 32'h90047F);
    check("noteon_pulses", 32'(pulses), 32'd1);
    check("noteon_state", 32'(state), 32'h0);

    // framing error on the status byte
    do_reset();
    send_byte(8'h90, 1'b0);
    wait_clks(2 * CPB);
    send_byte(8'h04);
    send_byte(8'h7F);
    wait_clks(2 * CPB);
    check("frame_bytes", 32'(out_bytes), 32'h0);
    check("frame_pulses", 32'(pulses), 32'd0);

    // glitch on the idle line, then a normal message
    do_reset();
    serial = 1'b0;
    wait_clks(CPB / 4);
    serial = 1'b1;
    wait_clks(2 * CPB);
    check("glitch_state", 32'(state), 32'h0);
    check("glitch_pulses", 32'(pulses), 32'd0);
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'h40);
    wait_clks(CPB);
    check("glitch_msg", 32'(out_bytes), 32'h903C40);
    check("glitch_msg_pulses", 32'(pulses), 32'd1);

    // program change: two-byte message
    send_byte(8'hC5);
    send_byte(8'h12);
    wait_clks(CPB);
    check("pgm_bytes", 32'(out_bytes), 32'hC51200);
    check("pgm_model", 32'(hold), 32'hC51200);
    check("pgm_pulses", 32'(pulses), 32'd2);

    // real-time byte inside a message, then running-status data
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'hF8);
    send_byte(8'h40);
    wait_clks(CPB);
    check("rt_bytes", 32'(out_bytes), 32'h903C40);
    check("rt_pulses", 32'(pulses), 32'd3);
    send_byte(8'h3E);
    send_byte(8'h00);
    wait_clks(2 * CPB);
`ifdef MIDI_RUNNING_STATUS_EN
    check("rs_bytes", 32'(out_bytes), 32'h903E00);
    check("rs_pulses", 32'(pulses), 32'd4);
`else
    check("rs_bytes", 32'(out_bytes), 32'h903C40);
    check("rs_pulses", 32'(pulses), 32'd3);
`endif

    // reset in the middle of a message
    do_reset();
    send_byte(8'h90);
    send_byte(8'h04);
    wait_clks(CPB);
    check("mid_state", 32'(state), 32'h8);
    do_reset();
    send_byte(8'h7F);
    wait_clks(2 * CPB);
    check("mid_bytes", 32'(out_bytes), 32'h0);
    check("mid_pulses", 32'(pulses), 32'd0);
    check("mid_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
